// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Provides the FSM state enum, the opcode constants of the supported
// subset, the ALU operation codes and the select encodings of the
// datapath muxes (ALU operand A/B, immediate format, result source).
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    // Opcodes of the supported subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Register-file write-data select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder for register-register and register-immediate
// arithmetic instructions.
// Ports:
//   is_r     in  1 : 1 = R-type (funct7_5 significant), 0 = I-type
//   funct3   in  3 : instruction funct3 field
//   funct7_5 in  1 : instruction bit 30
//   alu_op   out 3 : ALU operation code (ALU_ADD when not legal)
//   legal    out 1 : combination belongs to the supported subset
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       is_r,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_op,
    output logic       legal
);

    // funct7_5 only selects sub for R-type; any other R-type use of it is
    // illegal, while I-type ignores it (it is part of the immediate).
    logic w_r_alt;
    assign w_r_alt = is_r & funct7_5;

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (funct3)
            3'b000: begin
                alu_op = w_r_alt ? ALU_SUB : ALU_ADD;
                legal  = 1'b1;
            end
            3'b010: begin
                if (!w_r_alt) begin
                    alu_op = ALU_SLT;
                    legal  = 1'b1;
                end
            end
            3'b110: begin
                if (!w_r_alt) begin
                    alu_op = ALU_OR;
                    legal  = 1'b1;
                end
            end
            3'b111: begin
                if (!w_r_alt) begin
                    alu_op = ALU_AND;
                    legal  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for a shared RV32I datapath (single ALU,
// unified memory, PC/IR/ALU-out registers).
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   opcode, funct3, funct7_5      : fields of the instruction register
//   zero                          : ALU zero flag (branch compare)
//   mem_ready                     : memory completes current request
//   alu_op, alu_src_a, alu_src_b  : ALU operation and operand selects
//   imm_sel, result_src           : immediate format, write-data select
//   pc_src, adr_src               : next-PC source, memory address source
//   pc_we, ir_we, reg_we          : register write enables
//   mem_req, mem_we               : memory request / write
//   instr_done                    : pulse on the last cycle of an instruction
//   illegal                       : trap flag, held until reset
// Memory handshake: mem_req (and mem_we for stores) is asserted and held
// stable in the request state until the cycle where mem_ready is high;
// that cycle completes the transfer. mem_ready outside a request state is
// ignored.
module mc_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_sel,
    output logic [1:0] result_src,
    output logic       pc_src,
    output logic       adr_src,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;

    logic [2:0] w_dec_op;
    logic       w_dec_legal;

    logic [2:0] w_alu_op;
    logic [1:0] w_src_a, w_src_b, w_imm, w_res;
    logic       w_pc_src, w_adr_src, w_pc_we, w_ir_we, w_reg_we;
    logic       w_mem_req, w_mem_we, w_done, w_illegal;

    alu_decoder u_alu_decoder (
        .is_r     (r_state == S_EXEC_R),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (w_dec_op),
        .legal    (w_dec_legal)
    );

    always_comb begin
        w_next    = r_state;
        w_alu_op  = ALU_ADD;
        w_src_a   = SRCA_PC;
        w_src_b   = SRCB_REG;
        w_imm     = IMM_I;
        w_res     = RES_ALUOUT;
        w_pc_src  = 1'b0;
        w_adr_src = 1'b0;
        w_pc_we   = 1'b0;
        w_ir_we   = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_src_b   = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is computed speculatively into ALU-out
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                w_imm   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_src_a = SRCA_REG;
                w_src_b = SRCB_IMM;
                w_imm   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next  = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_res    = RES_MEM;
                w_reg_we = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                w_src_a  = SRCA_REG;
                w_src_b  = (r_state == S_EXEC_R) ? SRCB_REG : SRCB_IMM;
                w_alu_op = w_dec_op;
                w_next   = w_dec_legal ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                w_res    = RES_ALUOUT;
                w_reg_we = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                if (funct3 != 3'b000) begin
                    w_next = S_TRAP;
                end else begin
                    w_src_a  = SRCA_REG;
                    w_src_b  = SRCB_REG;
                    w_alu_op = ALU_SUB;
                    w_pc_src = 1'b1;
                    w_pc_we  = zero;
                    w_next   = S_FETCH;
                end
            end
            S_JAL: begin
                // Link value PC+4 comes live from the ALU; target sits in ALU-out
                w_src_a  = SRCA_OLDPC;
                w_src_b  = SRCB_FOUR;
                w_res    = RES_ALU;
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_src = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase
    end

    assign w_done = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Outputs are forced low for the whole reset interval, clock or not
    assign alu_op     = rst_n ? w_alu_op  : 3'b000;
    assign alu_src_a  = rst_n ? w_src_a   : 2'b00;
    assign alu_src_b  = rst_n ? w_src_b   : 2'b00;
    assign imm_sel    = rst_n ? w_imm     : 2'b00;
    assign result_src = rst_n ? w_res     : 2'b00;
    assign pc_src     = rst_n & w_pc_src;
    assign adr_src    = rst_n & w_adr_src;
    assign pc_we      = rst_n & w_pc_we;
    assign ir_we      = rst_n & w_ir_we;
    assign reg_we     = rst_n & w_reg_we;
    assign mem_req    = rst_n & w_mem_req;
    assign mem_we     = rst_n & w_mem_we;
    assign instr_done = rst_n & w_done;
    assign illegal    = rst_n & w_illegal;

endmodule
